// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA raster timing block.
//   - phase_e     : the four phases every sync axis walks through
//   - *_DEF       : default 640x480@60 timing constants
//   - axis_total  : total length of one axis from its four phase lengths
package vga_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam int CW_DEF       = 10;

  function automatic int axis_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). A counter
// running 0..TOTAL-1 plus a four-phase FSM (ACTIVE, FRONT, SYNC, BACK)
// that moves on when the counter reaches the last count of its phase.
// Ports:
//   clock    in   clock
//   reset_n  in   synchronous active-low reset (count=TOTAL-1, phase=BACK)
//   step     in   advance the axis by one on this edge
//   count    out  counter value after this edge (next-state value)
//   phase    out  phase after this edge (next-state value, phase_e encoding)
//   wrap     out  high when this edge takes the counter from TOTAL-1 to 0
// count/phase are the next-state values so the parent can register its
// outputs from them and stay aligned with the counter.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FRONT  = H_FRONT_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BACK   = H_BACK_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [1:0]    phase,
  output logic          wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  localparam logic [CW-1:0] LAST_ACTIVE = CW'(ACTIVE - 1);
  localparam logic [CW-1:0] LAST_FRONT  = CW'(ACTIVE + FRONT - 1);
  localparam logic [CW-1:0] LAST_SYNC   = CW'(ACTIVE + FRONT + SYNC - 1);
  localparam logic [CW-1:0] LAST_BACK   = CW'(TOTAL - 1);

  logic [CW-1:0] count_q, count_d;
  phase_e        phase_q, phase_d;

  assign wrap = step && (count_q == LAST_BACK);

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      case (phase_q)
        PH_ACTIVE: if (count_q == LAST_ACTIVE) phase_d = PH_FRONT;
        PH_FRONT:  if (count_q == LAST_FRONT)  phase_d = PH_SYNC;
        PH_SYNC:   if (count_q == LAST_SYNC)   phase_d = PH_BACK;
        PH_BACK:   if (wrap)                   phase_d = PH_ACTIVE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= LAST_BACK;
      phase_q <= PH_BACK;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count = count_d;
  assign phase = phase_d;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator (hsync, vsync, data-enable and
// pixel coordinates) in a single clock domain with an optional pixel
// clock-enable.
// Ports:
//   clock        in   pixel clock
//   reset_n      in   synchronous active-low reset
//   pixel_en     in   clock enable; everything holds while low
//   hsync        out  horizontal sync, at H_POL while asserted
//   vsync        out  vertical sync, at V_POL while asserted
//   de           out  high while the pixel is in the visible area
//   x, y         out  raw horizontal / vertical counters (incl. blanking)
//   line_start   out  high on the cycle where x==0
//   frame_start  out  high on the cycle where x==0 and y==0
// All outputs are registered from the counters' next-state values, so x/y,
// de and the syncs describe the same pixel in the same cycle.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FRONT  = H_FRONT_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BACK   = H_BACK_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FRONT  = V_FRONT_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BACK   = V_BACK_DEF,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   CW       = CW_DEF
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          pixel_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  logic [CW-1:0] h_count, v_count;
  logic [1:0]    h_phase, v_phase;
  logic          h_wrap, v_wrap;
  logic          v_step;

  // The vertical axis only moves on the edge that wraps the line.
  assign v_step = pixel_en && h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)
  ) u_h (
    .clock  (clock),
    .reset_n(reset_n),
    .step   (pixel_en),
    .count  (h_count),
    .phase  (h_phase),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)
  ) u_v (
    .clock  (clock),
    .reset_n(reset_n),
    .step   (v_step),
    .count  (v_count),
    .phase  (v_phase),
    .wrap   (v_wrap)
  );

  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [CW-1:0] x_q, y_q;

  // h_wrap means the next x is 0; v_wrap (which needs h_wrap) means the
  // next pixel is (0,0).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pixel_en) begin
      hsync_q       <= (h_phase == PH_SYNC) ? H_POL : ~H_POL;
      vsync_q       <= (v_phase == PH_SYNC) ? V_POL : ~V_POL;
      de_q          <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      x_q           <= h_count;
      y_q           <= v_count;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
module tb_vga_timing;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // default-timing DUT
  logic       rst_d, en_d;
  logic       hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;

  // small-timing DUT, active-high syncs
  logic       rst_s, en_s;
  logic       hs_s, vs_s, de_s, ls_s, fs_s;
  logic [3:0] x_s, y_s;

  vga_timing dut_d (
    .clock(clock), .reset_n(rst_d), .pixel_en(en_d),
    .hsync(hs_d), .vsync(vs_d), .de(de_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d)
  );

  vga_timing #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) dut_s (
    .clock(clock), .reset_n(rst_s), .pixel_en(en_s),
    .hsync(hs_s), .vsync(vs_s), .de(de_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s)
  );

  typedef struct {
    int x; int y;
    bit de; bit hs; bit vs; bit ls; bit fs;
  } out_t;

  typedef struct {
    bit   rst_n;
    bit   en;
    out_t exp;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  out_t qd[$];
  out_t qs[$];
  int   dh, dv, sh, sv;
  out_t dexp, sexp, last_d, last_s;

  function automatic out_t idle(bit hp, bit vp);
    out_t o;
    o.x = 0; o.y = 0; o.de = 0; o.hs = !hp; o.vs = !vp; o.ls = 0; o.fs = 0;
    return o;
  endfunction

  // Reference decode straight from the phase ranges.
  function automatic out_t decode(int h, int v, int ha, int hf, int hsw,
                                  int va, int vf, int vsw, bit hp, bit vp);
    out_t o;
    o.x  = h;
    o.y  = v;
    o.de = (h < ha) && (v < va);
    o.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : !hp;
    o.vs = (v >= va + vf && v < va + vf + vsw) ? vp : !vp;
    o.ls = (h == 0);
    o.fs = (h == 0) && (v == 0);
    return o;
  endfunction

  function automatic vec_t mk(bit r, bit e, int xx, int yy, bit de, bit hs,
                              bit vs, bit ls, bit fs);
    vec_t t;
    t.rst_n = r; t.en = e;
    t.exp.x = xx; t.exp.y = yy; t.exp.de = de; t.exp.hs = hs;
    t.exp.vs = vs; t.exp.ls = ls; t.exp.fs = fs;
    return t;
  endfunction

  task automatic check_out(input string tag, input out_t a, input out_t e);
    n_chk++;
    if (a.x != e.x || a.y != e.y || a.de != e.de || a.hs != e.hs ||
        a.vs != e.vs || a.ls != e.ls || a.fs != e.fs) begin
      n_fail++;
      $display("FAIL %s: got x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b, expected x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
               tag, a.x, a.y, a.de, a.hs, a.vs, a.ls, a.fs,
               e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic chk(input string tag, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, a, e);
    end
  endtask

  function automatic out_t sample_d();
    out_t o;
    o.x = int'(x_d); o.y = int'(y_d); o.de = de_d; o.hs = hs_d;
    o.vs = vs_d; o.ls = ls_d; o.fs = fs_d;
    return o;
  endfunction

  function automatic out_t sample_s();
    out_t o;
    o.x = int'(x_s); o.y = int'(y_s); o.de = de_s; o.hs = hs_s;
    o.vs = vs_s; o.ls = ls_s; o.fs = fs_s;
    return o;
  endfunction

  // One clock on the default DUT: model the edge, queue the expectation,
  // clock, then compare against the oldest queued expectation.
  task automatic cyc_d(input bit r, input bit e);
    rst_d = r; en_d = e;
    if (!r) begin
      dh = 799; dv = 524; dexp = idle(1'b0, 1'b0);
    end else if (e) begin
      if (dh == 799) begin dh = 0; dv = (dv == 524) ? 0 : dv + 1; end
      else dh++;
      dexp = decode(dh, dv, 640, 16, 96, 480, 10, 2, 1'b0, 1'b0);
    end
    qd.push_back(dexp);
    @(posedge clock); #1;
    last_d = sample_d();
    check_out("dflt", last_d, qd.pop_front());
  endtask

  task automatic cyc_s(input bit r, input bit e);
    rst_s = r; en_s = e;
    if (!r) begin
      sh = 6; sv = 4; sexp = idle(1'b1, 1'b1);
    end else if (e) begin
      if (sh == 6) begin sh = 0; sv = (sv == 4) ? 0 : sv + 1; end
      else sh++;
      sexp = decode(sh, sv, 4, 1, 1, 2, 1, 1, 1'b1, 1'b1);
    end
    qs.push_back(sexp);
    @(posedge clock); #1;
    last_s = sample_s();
    check_out("small", last_s, qs.pop_front());
  endtask

  initial begin
    vec_t tbl[15];
    int   hs_lo, hs_first, hs_last, de_fall, y_wrap_prev_x, cnt_a, cnt_b;
    int   ls_rise[$];
    int   fs_rise[$];
    bit   prev_de, prev_ls, prev_fs;
    out_t prev;

    // small-DUT vectors: {reset_n, pixel_en} -> outputs after the edge
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 1, 0, 0, 1, 1);
    tbl[2]  = mk(1, 1, 1, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 2, 0, 1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 3, 0, 1, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 1, 5, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(1, 1, 6, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 1, 0, 1, 1, 0, 0, 1, 0);
    tbl[10] = mk(1, 0, 0, 1, 1, 0, 0, 1, 0);
    tbl[11] = mk(1, 1, 1, 1, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 0, 1, 0, 0, 1, 1);

    rst_d = 1'b0; en_d = 1'b0; rst_s = 1'b0; en_s = 1'b0;
    dexp = idle(1'b0, 1'b0); sexp = idle(1'b1, 1'b1);
    @(posedge clock); #1;

    // ---- default timing, continuous enable, two lines ----
    cyc_d(0, 1);
    cyc_d(0, 0);
    hs_lo = 0; hs_first = -1; hs_last = -1; de_fall = -1; y_wrap_prev_x = -1;
    prev_de = 1'b0; prev = last_d;
    for (int k = 0; k < 1700; k++) begin
      cyc_d(1, 1);
      if (k == 0) begin
        chk("first_x", last_d.x, 0);
        chk("first_de", int'(last_d.de), 1);
        chk("first_fs", int'(last_d.fs), 1);
      end
      if (last_d.y == 0 && !last_d.hs) begin
        hs_lo++;
        if (hs_first < 0) hs_first = last_d.x;
        hs_last = last_d.x;
      end
      if (prev_de && !last_d.de && de_fall < 0) de_fall = last_d.x;
      if (last_d.ls) ls_rise.push_back(k);
      if (prev.y == 0 && last_d.y == 1) y_wrap_prev_x = prev.x;
      prev_de = last_d.de;
      prev = last_d;
    end
    chk("hsync_low_cycles", hs_lo, 96);
    chk("hsync_first_x", hs_first, 656);
    chk("hsync_last_x", hs_last, 751);
    chk("de_fall_x", de_fall, 640);
    chk("line_pulses", ls_rise.size(), 3);
    if (ls_rise.size() >= 3) begin
      chk("line_period_0", ls_rise[1] - ls_rise[0], 800);
      chk("line_period_1", ls_rise[2] - ls_rise[1], 800);
    end
    chk("y_inc_prev_x", y_wrap_prev_x, 799);

    // ---- reset in the middle of a frame ----
    for (int k = 0; k < 201; k++) cyc_d(1, 1);
    chk("mid_x", last_d.x, 300);
    for (int k = 0; k < 3; k++) begin
      cyc_d(0, k[0]);
      chk("mid_rst_hsync", int'(last_d.hs), 1);
    end
    cyc_d(1, 1);
    chk("rel_x", last_d.x, 0);
    chk("rel_y", last_d.y, 0);
    chk("rel_fs", int'(last_d.fs), 1);
    for (int k = 0; k < 5; k++) cyc_d(1, 1);

    // ---- default timing, enable every other cycle ----
    cyc_d(0, 1);
    ls_rise.delete();
    fs_rise.delete();
    prev_ls = last_d.ls; prev_fs = last_d.fs; hs_lo = 0;
    for (int k = 0; k < 3400; k++) begin
      cyc_d(1, (k % 2) == 0);
      if (last_d.ls && !prev_ls) ls_rise.push_back(k);
      if (last_d.fs && !prev_fs) fs_rise.push_back(k);
      if (last_d.y == 0 && !last_d.hs) hs_lo++;
      prev_ls = last_d.ls; prev_fs = last_d.fs;
    end
    chk("half_line_pulses", ls_rise.size(), 3);
    if (ls_rise.size() >= 3) begin
      chk("half_line_period_0", ls_rise[1] - ls_rise[0], 1600);
      chk("half_line_period_1", ls_rise[2] - ls_rise[1], 1600);
    end
    chk("half_frame_pulses", fs_rise.size(), 1);
    chk("half_hsync_low", hs_lo, 192);

    // ---- small timing, vector table ----
    for (int i = 0; i < 15; i++) begin
      rst_s = tbl[i].rst_n; en_s = tbl[i].en;
      @(posedge clock); #1;
      check_out($sformatf("vec%0d", i), sample_s(), tbl[i].exp);
    end

    // ---- small timing, three full frames ----
    cyc_s(0, 1);
    fs_rise.delete();
    prev_fs = last_s.fs; cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 105; k++) begin
      cyc_s(1, 1);
      if (last_s.fs && !prev_fs) fs_rise.push_back(k);
      if (k < 35 && last_s.vs) cnt_a++;
      if (k < 35 && last_s.de) cnt_b++;
      prev_fs = last_s.fs;
    end
    chk("small_vsync_cycles", cnt_a, 7);
    chk("small_de_cycles", cnt_b, 8);
    chk("small_frame_pulses", fs_rise.size(), 3);
    if (fs_rise.size() >= 3) begin
      chk("small_frame_period_0", fs_rise[1] - fs_rise[0], 35);
      chk("small_frame_period_1", fs_rise[2] - fs_rise[1], 35);
    end

    // ---- small timing, enable every other cycle ----
    cyc_s(0, 1);
    fs_rise.delete();
    prev_fs = last_s.fs; cnt_a = 0;
    for (int k = 0; k < 140; k++) begin
      cyc_s(1, (k % 2) == 0);
      if (last_s.fs && !prev_fs) fs_rise.push_back(k);
      if (k < 70 && last_s.vs) cnt_a++;
      prev_fs = last_s.fs;
    end
    chk("small_half_vsync", cnt_a, 14);
    chk("small_half_frames", fs_rise.size(), 2);
    if (fs_rise.size() >= 2)
      chk("small_half_period", fs_rise[1] - fs_rise[0], 70);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
